bf2_pipe: RTL and testbench
===========================

BF2_PIPE -- requirements
Module: bf2_pipe

Interface
REQ-001 Parameter W, default 16: two's-complement width of every data input and output.
REQ-002 Parameter SAT_EN, default 1: 1 = saturate results to W bits; 0 = wrap (keep the low W bits).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  input operand set is valid.
REQ-006 in_ready  output  1  block can accept the input this cycle.
REQ-007 mode  input  2  twiddle applied to operand B: 00 = x1, 01 = x(-j), 10 = x(+j), 11 = x(-1).
REQ-008 scale  input  1  1 = divide results by 2 with rounding.
REQ-009 ar1, ai1, ar2, ai2  input  W each  operand A (real, imag) and operand B (real, imag), signed.
REQ-010 out_valid  output  1  result set is valid.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 cr1, ci1, cr2, ci2  output  W each  signed results C1 = A+B', C2 = A-B'.
REQ-013 ovf  output  1  sticky overflow flag.
REQ-014 ovf_clr  input  1  clears ovf.

Function
REQ-015 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-016 mode and scale SHALL be sampled on the input transfer and travel with that operand set.
REQ-017 Stage 1 SHALL register the rotated operand B' = (br, bi), sign-extended to W+1 bits: 00 -> (ar2, ai2); 01 -> (ai2, -ar2); 10 -> (-ai2, ar2); 11 -> (-ar2, -ai2). Stage 1 SHALL also register A, scale and a valid bit v1.
REQ-018 Negating -2^(W-1) SHALL yield +2^(W-1) exactly, with no wrap, in the W+1-bit domain.
REQ-019 Stage 2 SHALL compute the results in W+2 bits: cr1 = ar1+br, cr2 = ar1-br, ci1 = ai1+bi, ci2 = ai1-bi.
REQ-020 When scale = 1, each result SHALL become (x+1) >>> 1 (arithmetic shift; ties round toward +inf) before narrowing.
REQ-021 Narrowing to W bits: SAT_EN = 1 clamps to [-2^(W-1), 2^(W-1)-1]; SAT_EN = 0 keeps the low W bits.
REQ-022 ovf SHALL be set on the output-register load of any set in which at least one of the four results was out of W-bit range before narrowing.
REQ-023 ovf SHALL stay set until an ovf_clr cycle; if set and clear occur in the same cycle, set wins.
REQ-024 Latency SHALL be exactly 2 cycles from input transfer to out_valid when there is no backpressure; throughput SHALL be 1 set per cycle.
REQ-025 Stall rule: adv2 = !out_valid || out_ready; adv1 = !v1 || adv2; in_ready = adv1 (combinational, no dependence on in_valid).
REQ-026 While out_valid && !out_ready, cr1..ci2 and out_valid SHALL hold steady; no set SHALL be lost or duplicated.
REQ-027 The maximum occupancy SHALL be 2 sets (stage 1 + output register); in_ready SHALL be 0 when both are full and out_ready = 0.
REQ-028 Data registers SHALL load only on their advance; registers with no valid data have don't-care contents, but outputs SHALL read 0 after reset until the first load.

Reset
REQ-029 While rst = 1: v1 = 0, out_valid = 0, cr1/ci1/cr2/ci2 = 0, ovf = 0, and in_ready = 1 from the first cycle after reset.
REQ-030 A reset asserted mid-operation SHALL discard all in-flight sets; no out_valid SHALL appear for them after reset.

Verification (W=16, SAT_EN=1, out_ready=1 unless stated)
REQ-031 mode=01, scale=0, A=(100,50), B=(10,20) -> two cycles later out_valid=1 with cr1=120, ci1=40, cr2=80, ci2=60, and ovf=0.
REQ-032 mode=00, scale=0, ar1=ar2=32767, others 0 -> cr1=32767 (saturated), cr2=0, ovf=1; ovf stays 1 until ovf_clr pulses, then reads 0.
REQ-033 Same operands with scale=1 -> cr1=32767, cr2=0, ovf=0; mode=11 with ar1=3, ar2=0 and scale=1 -> cr1=cr2=2.
REQ-034 mode=01, ar2=-32768, others 0 -> ci1=32767 with ovf=1, ci2=-32768; with SAT_EN=0, ci1=-32768.
REQ-035 Back-to-back sets S0..S3 with out_ready=0 for 4 cycles -> in_ready falls after S0 and S1 are accepted; outputs hold S0; on out_ready=1, results arrive in order S0..S3 with no gap.
REQ-036 rst pulsed one cycle after S0 is accepted -> out_valid stays 0, outputs read 0, in_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/bf2_pipe.sv
// Radix-2 butterfly with a selectable trivial twiddle on operand B.
// Two-stage pipeline: stage 1 registers the rotated B, stage 2 is the
// output register holding C1 = A+B' and C2 = A-B', optionally halved,
// then saturated or wrapped to W bits. Valid/ready handshake with a
// combinational ready chain; a sticky flag records any narrowing overflow.
module bf2_pipe #(
  parameter int W      = 16,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          mode,
  input  logic                scale,
  input  logic signed [W-1:0] ar1,
  input  logic signed [W-1:0] ai1,
  input  logic signed [W-1:0] ar2,
  input  logic signed [W-1:0] ai2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] cr1,
  output logic signed [W-1:0] ci1,
  output logic signed [W-1:0] cr2,
  output logic signed [W-1:0] ci2,
  output logic                ovf,
  input  logic                ovf_clr
);

  localparam logic signed [W-1:0] MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};

  // Optional halving: (x+1) >>> 1, ties go toward +inf.
  function automatic logic signed [W+1:0] rnd_half(input logic signed [W+1:0] x,
                                                   input logic                s);
    logic signed [W+1:0] t;
    t = x + $signed((W+2)'(1));
    return s ? (t >>> 1) : x;
  endfunction

  // True when x does not fit in W signed bits.
  function automatic logic out_of_range(input logic signed [W+1:0] x);
    return !((x[W+1:W-1] == 3'b000) || (x[W+1:W-1] == 3'b111));
  endfunction

  // Narrow to W bits: clamp when saturating, otherwise keep the low bits.
  function automatic logic signed [W-1:0] narrow(input logic signed [W+1:0] x);
    if (SAT_EN && out_of_range(x))
      return x[W+1] ? MIN_W : MAX_W;
    return $signed(x[W-1:0]);
  endfunction

  logic                r_v1;
  logic signed [W-1:0] r_ar1_p1, r_ai1_p1;
  logic signed [W:0]   r_br_p1, r_bi_p1;
  logic                r_scale_p1;

  logic                r_vld_p2;
  logic signed [W-1:0] r_cr1_p2, r_ci1_p2, r_cr2_p2, r_ci2_p2;
  logic                r_ovf;

  logic                w_adv1, w_adv2;
  logic signed [W:0]   w_ar2_x, w_ai2_x, w_br, w_bi;
  logic signed [W+1:0] w_cr1, w_ci1, w_cr2, w_ci2;
  logic signed [W+1:0] w_cr1_s, w_ci1_s, w_cr2_s, w_ci2_s;
  logic                w_ovf_any;

  assign w_adv2   = !r_vld_p2 || out_ready;
  assign w_adv1   = !r_v1 || w_adv2;
  assign in_ready = w_adv1;

  assign w_ar2_x = {ar2[W-1], ar2};
  assign w_ai2_x = {ai2[W-1], ai2};

  // Twiddle rotation of B in W+1 bits so negating the most negative value cannot wrap.
  always_comb begin
    w_br = w_ar2_x;
    w_bi = w_ai2_x;
    case (mode)
      2'b01:   begin w_br =  w_ai2_x; w_bi = -w_ar2_x; end
      2'b10:   begin w_br = -w_ai2_x; w_bi =  w_ar2_x; end
      2'b11:   begin w_br = -w_ar2_x; w_bi = -w_ai2_x; end
      default: begin w_br =  w_ar2_x; w_bi =  w_ai2_x; end
    endcase
  end

  // ---- stage 1: register A, rotated B and scale ----
  // Stage 1 valid and data advance together; data has no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
    end
    if (w_adv1 && in_valid) begin
      r_ar1_p1   <= ar1;
      r_ai1_p1   <= ai1;
      r_br_p1    <= w_br;
      r_bi_p1    <= w_bi;
      r_scale_p1 <= scale;
    end
  end

  assign w_cr1 = $signed({{2{r_ar1_p1[W-1]}}, r_ar1_p1}) + $signed({r_br_p1[W], r_br_p1});
  assign w_cr2 = $signed({{2{r_ar1_p1[W-1]}}, r_ar1_p1}) - $signed({r_br_p1[W], r_br_p1});
  assign w_ci1 = $signed({{2{r_ai1_p1[W-1]}}, r_ai1_p1}) + $signed({r_bi_p1[W], r_bi_p1});
  assign w_ci2 = $signed({{2{r_ai1_p1[W-1]}}, r_ai1_p1}) - $signed({r_bi_p1[W], r_bi_p1});

  assign w_cr1_s = rnd_half(w_cr1, r_scale_p1);
  assign w_ci1_s = rnd_half(w_ci1, r_scale_p1);
  assign w_cr2_s = rnd_half(w_cr2, r_scale_p1);
  assign w_ci2_s = rnd_half(w_ci2, r_scale_p1);

  assign w_ovf_any = out_of_range(w_cr1_s) || out_of_range(w_ci1_s) ||
                     out_of_range(w_cr2_s) || out_of_range(w_ci2_s);

  // ---- stage 2: output register ----
  // Output set loads on advance; outputs are cleared on reset so they read 0 until the first load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2 <= 1'b0;
      r_cr1_p2 <= '0;
      r_ci1_p2 <= '0;
      r_cr2_p2 <= '0;
      r_ci2_p2 <= '0;
    end else if (w_adv2) begin
      r_vld_p2 <= r_v1;
      if (r_v1) begin
        r_cr1_p2 <= narrow(w_cr1_s);
        r_ci1_p2 <= narrow(w_ci1_s);
        r_cr2_p2 <= narrow(w_cr2_s);
        r_ci2_p2 <= narrow(w_ci2_s);
      end
    end
  end

  // Sticky overflow: set on loading an overflowing set, set beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_adv2 && r_v1 && w_ovf_any) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign out_valid = r_vld_p2;
  assign cr1       = r_cr1_p2;
  assign ci1       = r_ci1_p2;
  assign cr2       = r_cr2_p2;
  assign ci2       = r_ci2_p2;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_bf2_pipe.sv
// Directed bench for bf2_pipe: a saturating instance and a wrapping
// instance share the same stimulus; expected values are hand-computed.
module tb_bf2_pipe;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [1:0]         mode;
  logic               scale;
  logic signed [15:0] ar1, ai1, ar2, ai2;
  logic               out_ready;
  logic               ovf_clr;

  logic               in_ready, out_valid, ovf;
  logic signed [15:0] cr1, ci1, cr2, ci2;
  logic               in_ready_w, out_valid_w, ovf_w;
  logic signed [15:0] cr1_w, ci1_w, cr2_w, ci2_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bf2_pipe #(.W(16), .SAT_EN(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .scale(scale), .ar1(ar1), .ai1(ai1), .ar2(ar2), .ai2(ai2),
    .out_valid(out_valid), .out_ready(out_ready),
    .cr1(cr1), .ci1(ci1), .cr2(cr2), .ci2(ci2), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  bf2_pipe #(.W(16), .SAT_EN(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .mode(mode), .scale(scale), .ar1(ar1), .ai1(ai1), .ar2(ar2), .ai2(ai2),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .cr1(cr1_w), .ci1(ci1_w), .cr2(cr2_w), .ci2(ci2_w), .ovf(ovf_w), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [1:0] m, input logic s,
                         input int a1, input int b1, input int a2, input int b2);
    mode  = m;
    scale = s;
    ar1   = 16'(a1);
    ai1   = 16'(b1);
    ar2   = 16'(a2);
    ai2   = 16'(b2);
  endtask

  // One input transfer, then confirm nothing appears after one edge.
  task automatic send(input logic [1:0] m, input logic s,
                      input int a1, input int b1, input int a2, input int b2);
    set_ops(m, s, a1, b1, a2, b2);
    in_valid = 1'b1;
    chk("send_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("lat_not_yet", int'(out_valid), 0);
    tick();
    chk("lat_valid", int'(out_valid), 1);
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int in_idx;
    int exp_idx;
    logic in_fire;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    set_ops(2'b00, 1'b0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_cr1", int'(cr1), 0);
    chk("rst_ci1", int'(ci1), 0);
    chk("rst_cr2", int'(cr2), 0);
    chk("rst_ci2", int'(ci2), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_w_in_ready", int'(in_ready_w), 1);
    chk("rst_w_out_valid", int'(out_valid_w), 0);
    chk("rst_w_ovf", int'(ovf_w), 0);
    rst = 1'b0;
    tick();

    // x(-j): B'=(20,-10)
    send(2'b01, 1'b0, 100, 50, 10, 20);
    chk("mj_cr1", int'(cr1), 120);
    chk("mj_ci1", int'(ci1), 40);
    chk("mj_cr2", int'(cr2), 80);
    chk("mj_ci2", int'(ci2), 60);
    chk("mj_ovf", int'(ovf), 0);
    tick();
    chk("mj_drain", int'(out_valid), 0);

    // positive overflow, no scaling
    send(2'b00, 1'b0, 32767, 0, 32767, 0);
    chk("sat_cr1", int'(cr1), 32767);
    chk("sat_cr2", int'(cr2), 0);
    chk("sat_ovf", int'(ovf), 1);
    chk("wrap_cr1", int'(cr1_w), -2);
    chk("wrap_ovf", int'(ovf_w), 1);
    tick();
    tick();
    chk("ovf_sticky", int'(ovf), 1);
    pulse_clr();
    chk("ovf_cleared", int'(ovf), 0);
    chk("ovf_w_cleared", int'(ovf_w), 0);

    // same operands halved: fits, no overflow
    send(2'b00, 1'b1, 32767, 0, 32767, 0);
    chk("half_cr1", int'(cr1), 32767);
    chk("half_cr2", int'(cr2), 0);
    chk("half_ovf", int'(ovf), 0);
    chk("half_w_cr1", int'(cr1_w), 32767);

    // x(-1), tie rounding 3/2 -> 2
    send(2'b11, 1'b1, 3, 0, 0, 0);
    chk("neg_cr1", int'(cr1), 2);
    chk("neg_cr2", int'(cr2), 2);

    // x(-j) with most negative ar2: bi=+32768 exactly
    send(2'b01, 1'b0, 0, 0, -32768, 0);
    chk("mn_ci1", int'(ci1), 32767);
    chk("mn_ci2", int'(ci2), -32768);
    chk("mn_ovf", int'(ovf), 1);
    chk("mn_w_ci1", int'(ci1_w), -32768);
    chk("mn_w_ci2", int'(ci2_w), -32768);
    tick();

    // set and clear in the same cycle: set wins
    set_ops(2'b01, 1'b0, 0, 0, -32768, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ovf_clr  = 1'b1;
    tick();
    ovf_clr  = 1'b0;
    chk("set_wins", int'(ovf), 1);
    pulse_clr();
    chk("ovf_clr2", int'(ovf), 0);
    tick();

    // backpressure: S_k = mode 00, A=(100k+5,k), B=(k+1,7) -> cr1=101k+6, ci2=k-7
    in_idx  = 0;
    exp_idx = 0;
    set_ops(2'b00, 1'b0, 5, 0, 1, 7);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = (cyc >= 4);
      #1;
      if (cyc == 1) chk("bp_ready_c1", int'(in_ready), 1);
      if (cyc == 2 || cyc == 3) begin
        chk("bp_ready_low", int'(in_ready), 0);
        chk("bp_hold_vld", int'(out_valid), 1);
        chk("bp_hold_cr1", int'(cr1), 6);
        chk("bp_hold_ci2", int'(ci2), -7);
      end
      if (cyc >= 4 && cyc <= 7) chk("bp_no_gap", int'(out_valid), 1);
      if (cyc == 8) chk("bp_no_dup", int'(out_valid), 0);
      if (out_valid && out_ready) begin
        chk("bp_order_cr1", int'(cr1), 101 * exp_idx + 6);
        chk("bp_order_ci2", int'(ci2), exp_idx - 7);
        exp_idx++;
      end
      in_fire = in_valid && in_ready;
      tick();
      if (in_fire) begin
        in_idx++;
        if (in_idx < 4)
          set_ops(2'b00, 1'b0, 100 * in_idx + 5, in_idx, in_idx + 1, 7);
        else
          in_valid = 1'b0;
      end
    end
    chk("bp_count", exp_idx, 4);
    chk("bp_in_count", in_idx, 4);

    // reset mid-flight discards the set in stage 1
    out_ready = 1'b1;
    set_ops(2'b00, 1'b0, 11, 22, 33, 44);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_in_ready", int'(in_ready), 1);
    chk("mr_out_valid", int'(out_valid), 0);
    chk("mr_cr1", int'(cr1), 0);
    chk("mr_ci2", int'(ci2), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_no_valid", int'(out_valid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
